// File: rtl/mem_slave_if.sv
// Request/response bus between a memory master and mem_slave.
// Signal names match the original flat port list of mem_slave.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef DEPTH
`define DEPTH 12
`endif

interface mem_slave_if;
  logic                   valid;
  logic                   wr_rd;
  logic [`ADDR_WIDTH-1:0] addr;
  logic [`WIDTH-1:0]      wdata;
  logic                   ready;
  logic [`WIDTH-1:0]      rdata;
  logic                   err;
  logic [7:0]             wr_cnt;
  logic [7:0]             rd_cnt;

  modport slave (
    input  valid, wr_rd, addr, wdata,
    output ready, rdata, err, wr_cnt, rd_cnt
  );

  modport master (
    output valid, wr_rd, addr, wdata,
    input  ready, rdata, err, wr_cnt, rd_cnt
  );
endinterface

// File: rtl/mem_slave.sv
// Single-cycle register-file memory slave with out-of-range error flag
// and saturating accepted-write/read counters.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef DEPTH
`define DEPTH 12
`endif

module mem_slave (
  input  logic        clk,
  input  logic        rst,
  mem_slave_if.slave  bus
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_ready;
  logic                w_in_range;
  logic [`WIDTH-1:0]   r_mem [`DEPTH];
  logic [`WIDTH-1:0]   r_rdata;
  logic                r_err;
  logic [7:0]          r_wr_cnt;
  logic [7:0]          r_rd_cnt;

  assign w_in_range = (32'(bus.addr) < 32'(`DEPTH));

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b0;
        if (bus.valid) w_next = ACK;
      end
      ACK: begin
        w_ready = 1'b1;
        if (!bus.valid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Reset wins over a concurrent request, so nothing is accepted while rst=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      for (int unsigned i = 0; i < `DEPTH; i++) begin
        r_mem[`ADDR_WIDTH'(i)] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (bus.valid) begin
        r_err <= !w_in_range;
        if (bus.wr_rd) begin
          if (w_in_range) begin
            r_mem[bus.addr] <= bus.wdata;
            if (r_wr_cnt != 8'hFF) r_wr_cnt <= r_wr_cnt + 8'd1;
          end
        end else begin
          r_rdata <= w_in_range ? r_mem[bus.addr] : '0;
          if (w_in_range && r_rd_cnt != 8'hFF) r_rd_cnt <= r_rd_cnt + 8'd1;
        end
      end else begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.ready  = w_ready;
  assign bus.rdata  = r_rdata;
  assign bus.err    = r_err;
  assign bus.wr_cnt = r_wr_cnt;
  assign bus.rd_cnt = r_rd_cnt;

endmodule

// File: doc/mem_slave.md
MEM_SLAVE -- requirements
Module: mem_slave

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst; all state SHALL update only on posedge clk.
REQ-002 The block SHALL use these sizing macros (name, default, meaning): `WIDTH, 16, data width; `ADDR_WIDTH, 4, address width; `DEPTH, 12, number of implemented words (≤ 2**`ADDR_WIDTH).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- valid, in, 1, request present this cycle
- wr_rd, in, 1, 1 = write, 0 = read
- addr, in, `ADDR_WIDTH, word address
- wdata, in, `WIDTH, write data
- ready, out, 1, request acknowledged, one cycle after valid
- rdata, out, `WIDTH, read data, valid while ready=1 for a read
- err, out, 1, the acknowledged request addressed a word ≥ `DEPTH
- wr_cnt, out, 8, accepted in-range write count, saturating
- rd_cnt, out, 8, accepted in-range read count, saturating

Function
REQ-004 Storage SHALL be `DEPTH words of `WIDTH bits, registered (no latches).
REQ-005 Handshake: ready SHALL be the value of valid registered one edge earlier. valid=1 at edge t gives ready=1 after edge t; valid=0 at edge t gives ready=0 after edge t.
REQ-006 A request is accepted at every edge where valid=1 and rst=0. There SHALL be no back-pressure, so back-to-back requests are accepted every cycle.
REQ-007 Write, accepted with addr < `DEPTH: mem[addr] SHALL be set to wdata at that edge.
REQ-008 Read, accepted with addr < `DEPTH: rdata SHALL be set to mem[addr] at that edge, giving 1-cycle latency aligned with ready.
REQ-009 A read at edge t+1 of an address written at edge t SHALL return the new data.
REQ-010 Out-of-range request (addr ≥ `DEPTH):
- a write SHALL NOT modify memory;
- a read SHALL set rdata to 0;
- err SHALL be 1 in the following cycle, aligned with ready.
REQ-011 err SHALL be 0 in any cycle where ready=0 or the acknowledged request was in range.
REQ-012 rdata SHALL hold its last value after an accepted write and in cycles with no accepted request.
REQ-013 wr_cnt SHALL increment by 1 per accepted in-range write and saturate at 255. rd_cnt SHALL do the same for in-range reads. Out-of-range requests SHALL NOT count.
REQ-014 Internal FSM states:
- IDLE: ready=0.
- ACK: ready=1.
- Transitions: IDLE→ACK on valid=1; ACK→ACK on valid=1; ACK→IDLE on valid=0; IDLE→IDLE on valid=0.
REQ-015 After reset, no output SHALL be X or Z. Every memory word SHALL hold a known value, so rdata is always known.

Reset
REQ-016 While rst=1 at an edge, the block SHALL:
- set ready, err and rdata to 0;
- clear wr_cnt and rd_cnt;
- put the FSM in IDLE;
- clear every memory word to 0.
REQ-017 rst SHALL take priority over any concurrent request; a request present with rst=1 SHALL be ignored and SHALL NOT be acknowledged.
REQ-018 If rst is asserted in the cycle after a request was accepted, ready SHALL be 0 in the next cycle and the pending read result SHALL be discarded (rdata=0).
REQ-019 The first request accepted after rst falls SHALL behave exactly as from IDLE.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then read addr 3 → one cycle later ready=1, rdata=0, err=0, rd_cnt=1.
- Write 0xA5A5 to addr 5, then read addr 5 on the next cycle → ready stays 1 for both acks, second ack rdata=0xA5A5, wr_cnt=1, rd_cnt=1.
- Write to addr 13 (≥ `DEPTH=12) → ready=1, err=1, memory unchanged, wr_cnt unchanged; a following read of addr 13 gives rdata=0, err=1.
- 300 back-to-back in-range writes → ready held at 1 throughout, wr_cnt=255 at the end.
- valid pulse of 1 cycle → ready is a 1-cycle pulse exactly one cycle later; ready=0 whenever valid was 0 on the previous edge.
- Write addr 2 = 0x1234, assert rst mid-stream with valid=1, release, then read addr 2 → ready=0 during reset, read returns 0, counters show rd_cnt=1, wr_cnt=0.
